// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
package seven_seg_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned ANODE_W  = 4;

    localparam logic [SEG_W-1:0]   SEG_OFF   = 7'h7F;
    localparam logic [ANODE_W-1:0] ANODE_OFF = 4'hF;

    typedef logic [1:0] digit_idx_t;

    // Active-low {a..g} patterns, entry 15 (F) first down to entry 0.
    localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [SEG_W-1:0]    seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed hex display driver with frame-aligned updates,
// optional leading-zero blanking and a commit acknowledge.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              blank_lz,
    output logic [SEG_W-1:0]  seven_segment,
    output logic [ANODE_W-1:0] anode,
    output logic              data_ack,
    output logic              frame_done
);

    localparam int unsigned     PRE_W   = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0]   presc_q, presc_d;
    digit_idx_t         digit_q, digit_d;
    logic [DATA_W-1:0]  disp_q, disp_d;
    logic [DATA_W-1:0]  pend_q, pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [ANODE_W-1:0] anode_q, anode_d;
    logic               ack_q, ack_d;
    logic               fdone_q, fdone_d;

    logic               tick_c, boundary_c, commit_c, blank_c;
    logic [NIBBLE_W-1:0] nibble_c;
    logic [SEG_W-1:0]   nibble_seg_c;

    // Select the nibble for the current slot and decide whether it is a leading zero.
    always_comb begin
        nibble_c = disp_q[3:0];
        blank_c  = 1'b0;
        case (digit_q)
            2'd1: begin
                nibble_c = disp_q[7:4];
                blank_c  = blank_lz && (disp_q[15:4] == '0);
            end
            2'd2: begin
                nibble_c = disp_q[11:8];
                blank_c  = blank_lz && (disp_q[15:8] == '0);
            end
            2'd3: begin
                nibble_c = disp_q[15:12];
                blank_c  = blank_lz && (disp_q[15:12] == '0);
            end
            default: begin
                nibble_c = disp_q[3:0];
                blank_c  = 1'b0;
            end
        endcase
    end

    hex_to_seven_seg u_hex (
        .nibble_i (nibble_c),
        .seg_o    (nibble_seg_c)
    );

    always_comb begin
        presc_d     = presc_q;
        digit_d     = digit_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        seg_d       = SEG_OFF;
        anode_d     = ANODE_OFF;
        ack_d       = 1'b0;
        fdone_d     = 1'b0;

        tick_c     = enable && (presc_q == PRE_MAX);
        // While disabled every cycle acts as a frame boundary so loads commit at once.
        boundary_c = enable ? (tick_c && (digit_q == 2'd3)) : 1'b1;
        commit_c   = boundary_c && pend_flag_q;

        if (enable) begin
            presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
            if (tick_c) begin
                digit_d = digit_q + 2'd1;
            end
            fdone_d = boundary_c;
            if (!blank_c) begin
                anode_d = ~(4'b0001 << digit_q);
                seg_d   = nibble_seg_c;
            end
        end else begin
            presc_d = '0;
            digit_d = '0;
        end

        if (commit_c) begin
            disp_d      = pend_q;
            ack_d       = 1'b1;
            pend_flag_d = 1'b0;
        end
        // A load on the commit cycle re-arms the pending flag for the next frame.
        if (data_valid) begin
            pend_d      = data_in;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            digit_q     <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            seg_q       <= SEG_OFF;
            anode_q     <= ANODE_OFF;
            ack_q       <= 1'b0;
            fdone_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            digit_q     <= digit_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            seg_q       <= seg_d;
            anode_q     <= anode_d;
            ack_q       <= ack_d;
            fdone_q     <= fdone_d;
        end
    end

    assign seven_segment = seg_q;
    assign anode         = anode_q;
    assign data_ack      = ack_q;
    assign frame_done    = fdone_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with a 4-cycle digit slot.
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] data_in;
    logic        data_valid;
    logic        blank_lz;
    logic [6:0]  seven_segment;
    logic [3:0]  anode;
    logic        data_ack;
    logic        frame_done;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV (4),
        .DATA_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .blank_lz      (blank_lz),
        .seven_segment (seven_segment),
        .anode         (anode),
        .data_ack      (data_ack),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            blz;
        logic [15:0]     data;
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    vec_t        vecs [9];
    exp_t        exp_q [$];
    logic [15:0] inj_d [16];
    int          n_vec = 0;
    int          n_err = 0;
    int          ack_cnt = 0;

    always @(negedge clk) begin
        if (data_ack === 1'b1) ack_cnt++;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_plain(input logic [15:0] d);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.an    = 4'hF;
            e.an[k] = 1'b0;
            e.seg   = seg_of(d[4*k +: 4]);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_vec(input int idx);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.an  = vecs[idx].an[k];
            e.seg = vecs[idx].seg[k];
            exp_q.push_back(e);
        end
    endtask

    // Bounded wait for the next frame_done pulse; n returns negedges waited.
    task automatic wait_fd(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 40);
        chk(name, 32'(frame_done), 32'd1);
    endtask

    // Entered on the negedge where frame_done is seen; checks the next 16 cycles.
    task automatic check_frame(input string tag, input logic [15:0] inj_mask);
        exp_t e;
        int   i;
        for (int s = 0; s < 4; s++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                i = s * 4 + c;
                chk($sformatf("%s_slot%0d_c%0d", tag, s, c), {21'd0, anode, seven_segment},
                    {21'd0, e.an, e.seg});
                chk($sformatf("%s_fd_c%0d", tag, i), 32'(frame_done), 32'(i == 15));
                data_valid = inj_mask[i];
                if (inj_mask[i]) data_in = inj_d[i];
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic apply_vec(input int idx);
        int n;
        int ack0;
        ack0       = ack_cnt;
        blank_lz   = vecs[idx].blz;
        data_in    = vecs[idx].data;
        data_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            data_valid = 1'b0;
            n++;
        end while (data_ack !== 1'b1 && n < 40);
        chk($sformatf("v%0d_ack", idx), 32'(data_ack), 32'd1);
        chk($sformatf("v%0d_ack_at_fd", idx), 32'(frame_done), 32'd1);
        push_vec(idx);
        check_frame($sformatf("v%0d", idx), 16'h0000);
        #1;
        chk($sformatf("v%0d_ack_count", idx), 32'(ack_cnt - ack0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int ack0;

        reset = 1'b1; enable = 1'b1; data_valid = 1'b0; data_in = '0; blank_lz = 1'b0;
        for (int i = 0; i < 16; i++) inj_d[i] = '0;

        vecs[0] = '{blz: 1'b0, data: 16'h1A3F, an: {4'h7, 4'hB, 4'hD, 4'hE},
                    seg: {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}};
        vecs[1] = '{blz: 1'b1, data: 16'h0005, an: {4'hF, 4'hF, 4'hF, 4'hE},
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'b0100100}};
        vecs[2] = '{blz: 1'b1, data: 16'h0000, an: {4'hF, 4'hF, 4'hF, 4'hE},
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'b0000001}};
        vecs[3] = '{blz: 1'b0, data: 16'h0000, an: {4'h7, 4'hB, 4'hD, 4'hE},
                    seg: {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
        vecs[4] = '{blz: 1'b1, data: 16'h0250, an: {4'hF, 4'hB, 4'hD, 4'hE},
                    seg: {7'h7F, 7'b0010010, 7'b0100100, 7'b0000001}};
        vecs[5] = '{blz: 1'b0, data: 16'hBEEF, an: {4'h7, 4'hB, 4'hD, 4'hE},
                    seg: {7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000}};
        vecs[6] = '{blz: 1'b1, data: 16'hC0D8, an: {4'h7, 4'hB, 4'hD, 4'hE},
                    seg: {7'b0110001, 7'b0000001, 7'b1000010, 7'b0000000}};
        vecs[7] = '{blz: 1'b0, data: 16'h9764, an: {4'h7, 4'hB, 4'hD, 4'hE},
                    seg: {7'b0000100, 7'b0001111, 7'b0100000, 7'b1001100}};
        vecs[8] = '{blz: 1'b1, data: 16'h0100, an: {4'hF, 4'hB, 4'hD, 4'hE},
                    seg: {7'h7F, 7'b1001111, 7'b0000001, 7'b0000001}};

        // Reset state with the clock running.
        repeat (3) @(negedge clk);
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_seg", 32'(seven_segment), 32'h7F);
        chk("rst_ack", 32'(data_ack), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;

        // Idle scan of the cleared value.
        @(negedge clk);
        chk("idle_first_slot", {21'd0, anode, seven_segment}, {21'd0, 4'hE, 7'b0000001});
        wait_fd("idle_fd", n);
        chk("idle_fd_latency", 32'(n), 32'd15);
        push_plain(16'h0000);
        check_frame("idle", 16'h0000);

        for (int v = 0; v < 9; v++) apply_vec(v);

        // Two loads in one frame plus one on the boundary cycle itself.
        blank_lz = 1'b0;
        ack0     = ack_cnt;
        inj_d[2] = 16'h1111; inj_d[6] = 16'h2222; inj_d[14] = 16'h3333;
        push_plain(16'h0100);
        check_frame("lw_hold", 16'h4044);
        #1;
        chk("lw_ack_first", 32'(ack_cnt - ack0), 32'd1);
        push_plain(16'h2222);
        check_frame("lw_2222", 16'h0000);
        push_plain(16'h3333);
        check_frame("lw_3333", 16'h0000);
        #1;
        chk("lw_ack_total", 32'(ack_cnt - ack0), 32'd2);

        // Disabled: display dark, loads commit immediately.
        ack0   = ack_cnt;
        enable = 1'b0;
        @(negedge clk);
        chk("dis_dark", {21'd0, anode, seven_segment}, {21'd0, 4'hF, 7'h7F});
        chk("dis_fd", 32'(frame_done), 32'd0);
        data_in = 16'hBEEF; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk("dis_ack_early", 32'(data_ack), 32'd0);
        @(negedge clk);
        chk("dis_ack", 32'(data_ack), 32'd1);
        chk("dis_anode", 32'(anode), 32'hF);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_slot0", {21'd0, anode, seven_segment}, {21'd0, 4'hE, 7'b0111000});
        wait_fd("reen_fd", n);
        chk("reen_fd_latency", 32'(n), 32'd15);
        push_plain(16'hBEEF);
        check_frame("reen", 16'h0000);
        #1;
        chk("dis_ack_count", 32'(ack_cnt - ack0), 32'd1);

        // Asynchronous reset during slot 2 with a value pending.
        repeat (9) @(negedge clk);
        chk("pre_rst_slot2", 32'(anode), 32'hB);
        data_in = 16'h5A5A; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        ack0 = ack_cnt;
        #2 reset = 1'b1;
        #1;
        chk("arst_anode", 32'(anode), 32'hF);
        chk("arst_seg", 32'(seven_segment), 32'h7F);
        chk("arst_ack", 32'(data_ack), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_restart", {21'd0, anode, seven_segment}, {21'd0, 4'hE, 7'b0000001});
        wait_fd("arst_fd", n);
        chk("arst_fd_latency", 32'(n), 32'd15);
        push_plain(16'h0000);
        check_frame("arst", 16'h0000);
        #1;
        chk("arst_no_ack", 32'(ack_cnt - ack0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Downstream display stage of the single-cycle MIPS processor top level. It takes a 16-bit value chosen by the processor/switch logic and time-multiplexes it as four hex digits onto the Nexys3 common-anode seven-segment display. Updates apply only at frame boundaries, so no digit ever shows a mix of old and new data. Optional leading-zero blanking is provided, and a one-cycle acknowledge is returned to the producer.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (100 MHz gives 2 kHz per digit, 500 Hz per frame); legal range ≥ 2
DATA_W, 16, display value width; fixed at 4 nibbles, any other value is illegal

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scan display; 0 = all digits dark
data_in  in  16  value to display; nibble 0 goes to the rightmost digit
data_valid  in  1  one-cycle load strobe for data_in
blank_lz  in  1  1 = blank leading zero digits
seven_segment  out  7  active-low segments; bit6 = a … bit0 = g
anode  out  4  active-low digit enables; anode[0] is the rightmost digit
data_ack  out  1  one-cycle pulse when a pending value is committed to the display
frame_done  out  1  one-cycle pulse at the end of each digit-3 slot

Behaviour:
- Reset (async, active-high). Cleared state:
  - seven_segment = 7'h7F, anode = 4'hF
  - data_ack = 0, frame_done = 0
  - prescaler = 0, digit_idx = 0
  - disp_reg = 0, pend_reg = 0, pend_flag = 0
- Prescaler counts 0 … REFRESH_DIV-1. tick = (prescaler == REFRESH_DIV-1); the prescaler wraps to 0 on tick.
- On tick, digit_idx advances 0→1→2→3→0.
- boundary = tick && digit_idx == 3. On boundary, frame_done = 1 in the next cycle.
- Capture: on data_valid, pend_reg ← data_in and pend_flag ← 1. A later data_valid before the next boundary overwrites pend_reg (last one wins).
- Commit: on boundary with pend_flag = 1:
  - disp_reg ← pend_reg
  - data_ack = 1 in the next cycle
  - pend_flag ← 0, unless data_valid is high in the same cycle
- Simultaneous data_valid and boundary:
  - the old pend_reg is committed;
  - the new data_in is captured into pend_reg;
  - pend_flag stays 1 and the new value commits at the following boundary.
  - If pend_flag was 0, nothing commits and the new value waits for the next boundary.
- Outputs are registered, with 1-cycle latency from digit_idx/disp_reg to anode/seven_segment.
- For slot k, anode = ~(1 << k) and seven_segment = hex pattern of disp_reg[4k+3:4k].
- Hex patterns, {a..g} active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Leading-zero blanking: with blank_lz = 1, slot k ∈ {3, 2, 1} is blanked (anode = 4'hF, seven_segment = 7'h7F) when nibbles 3..k of disp_reg are all zero. Slot 0 is never blanked, so value 0 shows "0".
- enable = 0:
  - prescaler and digit_idx are held at 0; anode = 4'hF, seven_segment = 7'h7F; frame_done = 0.
  - Every cycle with pend_flag = 1 counts as a boundary: commit happens immediately and data_ack pulses.
  - Re-enabling starts at slot 0 with prescaler = 0.
- Reset mid-frame returns the block to the cleared state immediately (asynchronous). Pending data is discarded and no data_ack is issued.
- Only one anode is ever low at a time, including across slot transitions.

Decomposition:
- Package seven_seg_pkg:
  - SEG_OFF = 7'h7F, ANODE_OFF = 4'hF
  - the 16-entry hex segment constant table
  - digit index type (2 bits)
- Sub-module hex_to_seven_seg: purely combinational, 4-bit in, 7-bit active-low out. Instantiated once on the muxed nibble.
- Prescaler, scan counter, pending/commit logic and output registers stay in seven_seg_scan_ctrl.

Test Plan:
- Reset, then idle with REFRESH_DIV = 4 and enable = 1 → anode cycles E, D, B, 7, each held 4 cycles, all digits show "0" pattern 0000001; frame_done pulses every 16 cycles.
- data_valid with data_in = 16'h1A3F mid-frame → display unchanged until boundary; data_ack pulses once. The next frame shows F (0111000) on anode E, 3 (0000110) on D, A (0001000) on B, 1 (1001111) on 7.
- blank_lz = 1, value 16'h0005 → anodes 7 and B and D stay dark (F in their slots); anode E shows 0100100. With value 16'h0000 only slot 0 lights, showing 0000001.
- data_valid 16'h1111 then 16'h2222 in the same frame, plus 16'h3333 on the exact boundary cycle → 16'h2222 commits at the first boundary, 16'h3333 at the next; exactly two data_ack pulses.
- enable = 0 with data_valid 16'hBEEF → anode = F, data_ack the next cycle. Re-enable → slot 0 shows F (0111000) first, and scanning resumes from prescaler = 0.
- Assert reset during slot 2 with a pending value → outputs go to F/7F immediately. After release, display is 0, no data_ack occurs, and the scan restarts at slot 0.
